// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master with a single chip-select.
// Word width, SCLK divider, CPOL/CPHA and bit order are all configurable.
// The mode and bit order are latched per transaction on start.
// The start/busy/valid handshake faces the core logic.
// sclk/mosi/cs_n/miso face the pin wrapper.
module spi_master_param #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_done
);

    localparam int CNT_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  div_cnt;   // clk cycles within the current half-period
    logic [BIT_W-1:0]  bit_cnt;   // index of the bit currently being exchanged
    logic              phase;     // 0: leading half of a bit, 1: trailing half
    logic [DATA_W-1:0] tx_sr;     // bits still waiting to be driven, next one at the head
    logic [DATA_W-1:0] rx_sr;     // received bits being assembled
    logic              cpol_q;
    logic              cpha_q;
    logic              lsb_q;

    // Bit at the head of the transmit shifter for the selected order.
    function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    // Drop the head bit so the next bit to send becomes the head.
    function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
    endfunction

    // Insert a received bit so the first bit lands on bit 0 (lsb) or MSB.
    function automatic logic [DATA_W-1:0] push_bit(input logic [DATA_W-1:0] v, input logic lsb,
                                                   input logic b);
        return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    // Transaction sequencer: all outputs are registered here.
    // NOTE: every state element uses non-blocking assignment so that all
    // registers update together from the values they held before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            phase    <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle.
            // Only the IDLE-entry branch raises them, so they last exactly one cycle.
            rx_valid <= 1'b0;
            tx_done  <= 1'b0;

            case (state)
                IDLE: begin
                    sclk <= cpol_q;
                    if (start) begin
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        lsb_q   <= lsb_first;
                        sclk    <= cpol;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        phase   <= 1'b0;
                        rx_sr   <= '0;
                        if (!cpha) begin
                            // With cpha=0 the first bit must be valid before the first leading edge.
                            mosi  <= head_bit(tx_data, lsb_first);
                            tx_sr <= drop_head(tx_data, lsb_first);
                        end else begin
                            tx_sr <= tx_data;
                        end
                        state <= LEAD;
                    end
                end

                LEAD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        if (!phase) begin
                            // Leading edge.
                            if (!cpha_q) begin
                                rx_sr <= push_bit(rx_sr, lsb_q, miso);
                            end else begin
                                mosi  <= head_bit(tx_sr, lsb_q);
                                tx_sr <= drop_head(tx_sr, lsb_q);
                            end
                            phase <= 1'b1;
                        end else begin
                            // Trailing edge.
                            if (cpha_q) begin
                                rx_sr <= push_bit(rx_sr, lsb_q, miso);
                            end else if (bit_cnt != BIT_LAST) begin
                                mosi  <= head_bit(tx_sr, lsb_q);
                                tx_sr <= drop_head(tx_sr, lsb_q);
                            end
                            phase <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= TRAIL;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                TRAIL: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        sclk     <= cpol_q;
                        cs_n     <= 1'b1;
                        busy     <= 1'b0;
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                        tx_done  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
